// File: rtl/line_refill_fsm.sv
// Miss-handling engine for a single cache line: optional word-by-word write-back
// of the dirty victim, word-by-word refill from memory, then a tag commit.
module line_refill_fsm #(
  parameter int unsigned TAG_WIDTH    = 24,
  parameter int unsigned SET_WIDTH    = 4,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // Miss request from the cache controller
  input  logic                    req_i,
  input  logic                    req_wb_i,
  input  logic [TAG_WIDTH-1:0]    req_tag_i,
  input  logic [TAG_WIDTH-1:0]    victim_tag_i,
  input  logic [SET_WIDTH-1:0]    index_i,
  output logic                    busy_o,
  output logic                    done_o,
  // Line storage controls
  output logic                    line_write_en_o,
  output logic                    line_update_en_o,
  output logic                    line_set_valid_o,
  output logic                    line_set_dirty_o,
  output logic [TAG_WIDTH-1:0]    line_set_tag_o,
  output logic [OFFSET_WIDTH-3:0] line_offset_o,
  output logic [31:0]             line_write_data_o,
  input  logic [31:0]             line_read_data_i,
  // Memory bus
  output logic [31:0]             mem_addr_o,
  output logic                    mem_ren_o,
  output logic                    mem_wen_o,
  output logic [31:0]             mem_wdata_o,
  input  logic [31:0]             mem_rdata_i,
  input  logic                    mem_ready_i
);

  // Address assembly below assumes TAG_WIDTH + SET_WIDTH + OFFSET_WIDTH == 32
  // and OFFSET_WIDTH >= 3 (at least two words per line).
  localparam int unsigned CntW = OFFSET_WIDTH - 2;

  typedef enum logic [1:0] {
    StIdle,
    StWb,
    StRefill,
    StCommit
  } state_e;

  state_e               r_state;
  logic [CntW-1:0]      r_cnt;
  logic [TAG_WIDTH-1:0] r_req_tag;
  logic [TAG_WIDTH-1:0] r_victim_tag;
  logic [SET_WIDTH-1:0] r_index;

  logic                 w_last_word;

  assign w_last_word = (r_cnt == {CntW{1'b1}});

  // Sequencing: accept in idle, step the word counter on each memory handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_req_tag    <= '0;
      r_victim_tag <= '0;
      r_index      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_i) begin
            r_req_tag    <= req_tag_i;
            r_victim_tag <= victim_tag_i;
            r_index      <= index_i;
            r_cnt        <= '0;
            r_state      <= req_wb_i ? StWb : StRefill;
          end
        end
        StWb: begin
          if (mem_ready_i) begin
            r_cnt <= r_cnt + {{(CntW-1){1'b0}}, 1'b1};
            if (w_last_word) r_state <= StRefill;
          end
        end
        StRefill: begin
          if (mem_ready_i) begin
            r_cnt <= r_cnt + {{(CntW-1){1'b0}}, 1'b1};
            if (w_last_word) r_state <= StCommit;
          end
        end
        StCommit: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Output decode from the state register; idle (and therefore reset) drives all zeros.
  always_comb begin
    busy_o            = 1'b0;
    done_o            = 1'b0;
    line_write_en_o   = 1'b0;
    line_update_en_o  = 1'b0;
    line_set_valid_o  = 1'b0;
    line_set_dirty_o  = 1'b0;
    line_set_tag_o    = '0;
    line_offset_o     = '0;
    line_write_data_o = '0;
    mem_addr_o        = '0;
    mem_ren_o         = 1'b0;
    mem_wen_o         = 1'b0;
    mem_wdata_o       = '0;
    unique case (r_state)
      StIdle: begin
      end
      StWb: begin
        busy_o         = 1'b1;
        // Presenting the victim tag makes the line hit, so its read data is ungated.
        line_set_tag_o = r_victim_tag;
        line_offset_o  = r_cnt;
        mem_wen_o      = 1'b1;
        mem_wdata_o    = line_read_data_i;
        mem_addr_o     = {r_victim_tag, r_index, r_cnt, 2'b00};
      end
      StRefill: begin
        busy_o            = 1'b1;
        line_set_tag_o    = r_req_tag;
        line_offset_o     = r_cnt;
        line_write_data_o = mem_rdata_i;
        // Line captures the word on the same edge the memory completes it.
        line_write_en_o   = mem_ready_i;
        mem_ren_o         = 1'b1;
        mem_addr_o        = {r_req_tag, r_index, r_cnt, 2'b00};
      end
      StCommit: begin
        busy_o           = 1'b1;
        done_o           = 1'b1;
        line_update_en_o = 1'b1;
        line_set_valid_o = 1'b1;
        line_set_dirty_o = 1'b0;
        line_set_tag_o   = r_req_tag;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_line_refill_fsm.sv
// Randomized bench for line_refill_fsm against a transaction-level model:
// each miss is an ordered list of word operations plus a commit.
module tb_line_refill_fsm;

  localparam int TW = 24;
  localparam int SW = 4;
  localparam int OW = 4;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i, req_wb_i;
  logic [TW-1:0] req_tag_i, victim_tag_i;
  logic [SW-1:0] index_i;
  logic          busy_o, done_o;
  logic          line_write_en_o, line_update_en_o, line_set_valid_o, line_set_dirty_o;
  logic [TW-1:0] line_set_tag_o;
  logic [OW-3:0] line_offset_o;
  logic [31:0]   line_write_data_o, line_read_data_i;
  logic [31:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic          mem_ren_o, mem_wen_o, mem_ready_i;

  // Bench-owned line contents (victim data) and memory data for the refill.
  logic [31:0] line_mem [N];
  logic [31:0] rd_vals  [N];

  int n_checks = 0;
  int n_errors = 0;

  assign line_read_data_i = line_mem[line_offset_o];

  always #5 clk = ~clk;

  line_refill_fsm #(
    .TAG_WIDTH   (TW),
    .SET_WIDTH   (SW),
    .OFFSET_WIDTH(OW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .req_wb_i         (req_wb_i),
    .req_tag_i        (req_tag_i),
    .victim_tag_i     (victim_tag_i),
    .index_i          (index_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .line_write_en_o  (line_write_en_o),
    .line_update_en_o (line_update_en_o),
    .line_set_valid_o (line_set_valid_o),
    .line_set_dirty_o (line_set_dirty_o),
    .line_set_tag_o   (line_set_tag_o),
    .line_offset_o    (line_offset_o),
    .line_write_data_o(line_write_data_o),
    .line_read_data_i (line_read_data_i),
    .mem_addr_o       (mem_addr_o),
    .mem_ren_o        (mem_ren_o),
    .mem_wen_o        (mem_wen_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rdata_i      (mem_rdata_i),
    .mem_ready_i      (mem_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // OR of every output: must be zero in reset and in idle.
  function automatic logic any_out();
    return |{busy_o, done_o, line_write_en_o, line_update_en_o, line_set_valid_o,
             line_set_dirty_o, line_set_tag_o, line_offset_o, line_write_data_o,
             mem_addr_o, mem_ren_o, mem_wen_o, mem_wdata_o};
  endfunction

  // stall_mode: 0 = always ready, 1 = random stalls, 2 = 3-cycle stall on refill word 1.
  // poke: re-request with a different tag during refill word 2 and in the commit cycle.
  // abort_k: if >= 0, assert reset mid-cycle while operation abort_k is on the bus.
  task automatic run_miss(input bit wb, input logic [TW-1:0] tag, input logic [TW-1:0] vtag,
                          input logic [SW-1:0] idx, input int stall_mode, input bit poke,
                          input int abort_k);
    int          n_ops, k, cycles, stalls, stall_cnt, w;
    bit          is_wr, ready, poked, finished;
    logic [1:0]  wl;
    logic [31:0] exp_addr;
    n_ops = wb ? 2 * N : N;
    k = 0; cycles = 0; stalls = 0; stall_cnt = 0; poked = 0; finished = 0;

    @(negedge clk);
    req_i = 1'b1; req_wb_i = wb; req_tag_i = tag; victim_tag_i = vtag; index_i = idx;
    mem_ready_i = 1'b0; mem_rdata_i = $urandom;
    #1 check("idle_quiet", 32'(any_out()), 32'd0);
    @(posedge clk);
    #1;
    // Scramble request inputs: the latched copies must not follow them.
    req_i = 1'b0; req_wb_i = 1'($urandom); req_tag_i = TW'($urandom);
    victim_tag_i = TW'($urandom); index_i = SW'($urandom);

    while (cycles < 300 && !finished) begin
      @(negedge clk);
      cycles++;
      req_i = 1'b0;
      if (k < n_ops) begin
        is_wr = wb && (k < N);
        w     = k % N;
        wl    = w[1:0];
        case (stall_mode)
          0: ready = 1'b1;
          1: ready = ($urandom_range(0, 3) != 0);
          default: begin
            ready = 1'b1;
            if (!is_wr && w == 1 && stall_cnt < 3) begin
              ready = 1'b0;
              stall_cnt++;
            end
          end
        endcase
        mem_ready_i = ready;
        mem_rdata_i = is_wr ? $urandom : rd_vals[w];
        if (poke && !is_wr && w == 2 && !poked) begin
          req_i = 1'b1; req_wb_i = 1'b1; req_tag_i = ~tag; poked = 1'b1;
        end
        exp_addr = {(is_wr ? vtag : tag), idx, wl, 2'b00};
        #1;
        check("busy", 32'(busy_o), 32'd1);
        check("done_early", 32'(done_o), 32'd0);
        check("mem_addr", mem_addr_o, exp_addr);
        check("mem_wen", 32'(mem_wen_o), 32'(is_wr));
        check("mem_ren", 32'(mem_ren_o), 32'(!is_wr));
        check("offset", 32'(line_offset_o), 32'(w));
        check("set_tag", 32'(line_set_tag_o), 32'(is_wr ? vtag : tag));
        check("update_en", 32'(line_update_en_o), 32'd0);
        if (is_wr) begin
          check("wb_wdata", mem_wdata_o, line_mem[w]);
          check("wb_line_wen", 32'(line_write_en_o), 32'd0);
        end else begin
          check("rf_line_wen", 32'(line_write_en_o), 32'(ready));
          check("rf_line_wdata", line_write_data_o, rd_vals[w]);
        end
        if (abort_k >= 0 && k == abort_k) begin
          #2 rst_i = 1'b1;
          #1 check("rst_quiet", 32'(any_out()), 32'd0);
          repeat (2) begin
            @(negedge clk);
            #1 check("rst_hold_quiet", 32'(any_out()), 32'd0);
          end
          rst_i = 1'b0;
          mem_ready_i = 1'b1;
          repeat (N + 3) begin
            @(negedge clk);
            #1;
            check("post_rst_done", 32'(done_o), 32'd0);
            check("post_rst_busy", 32'(busy_o), 32'd0);
            check("post_rst_upd", 32'(line_update_en_o), 32'd0);
          end
          return;
        end
        if (ready) k++;
        else stalls++;
      end else begin
        mem_ready_i = 1'($urandom);
        if (poke) begin
          req_i = 1'b1; req_wb_i = 1'b0; req_tag_i = ~tag;
        end
        #1;
        check("done", 32'(done_o), 32'd1);
        check("commit_upd", 32'(line_update_en_o), 32'd1);
        check("commit_valid", 32'(line_set_valid_o), 32'd1);
        check("commit_dirty", 32'(line_set_dirty_o), 32'd0);
        check("commit_tag", 32'(line_set_tag_o), 32'(tag));
        check("commit_bus", 32'({mem_ren_o, mem_wen_o, line_write_en_o}), 32'd0);
        check("latency", 32'(cycles), 32'(n_ops + 1 + stalls));
        finished = 1'b1;
      end
    end
    if (!finished) check("timeout", 32'd0, 32'd1);
    for (int i = 0; i < N; i++) line_mem[i] = rd_vals[i];
    if (poke) begin
      @(negedge clk);
      req_i = 1'b0;
      #1 check("poke_idle", 32'(any_out()), 32'd0);
    end
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; req_wb_i = 1'b0; req_tag_i = '0; victim_tag_i = '0;
    index_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < N; i++) begin
      line_mem[i] = 32'h100 + 32'(i);
      rd_vals[i]  = 32'h10 + 32'(i);
    end
    #12 check("reset_quiet", 32'(any_out()), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Clean miss, then back-to-back dirty miss, then stalled miss.
    run_miss(1'b0, 24'hABCDEF, 24'h123456, 4'h3, 0, 1'b0, -1);
    for (int i = 0; i < N; i++) begin
      line_mem[i] = 32'h100 + 32'(i);
      rd_vals[i]  = 32'h20 + 32'(i);
    end
    run_miss(1'b1, 24'h5A5A5A, 24'h000111, 4'h7, 0, 1'b0, -1);
    run_miss(1'b0, 24'h0C0FFE, 24'h000000, 4'h9, 2, 1'b0, -1);
    // Ignored requests during refill and commit.
    run_miss(1'b0, 24'hBEEF01, 24'h000000, 4'hA, 0, 1'b1, -1);
    // Reset during refill with cnt = 2.
    run_miss(1'b0, 24'h777777, 24'h000000, 4'h1, 0, 1'b0, 2);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) rd_vals[i] = $urandom;
      run_miss(1'($urandom), TW'($urandom), TW'($urandom), SW'($urandom), 1,
               ($urandom_range(0, 3) == 0), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/line_refill_fsm.md
Name: line_refill_fsm

Overview:
- Miss-handling engine sitting directly beside a single cache line, between the line storage and the memory bus.
- On a miss it optionally writes back the dirty victim line word by word, then refills the line from memory word by word. It does this by driving the line's write_en/update_en/offset/tag/data controls.
- Finally it commits the new tag with valid=1, dirty=0, and pulses done to the cache controller.

Parameters:
- TAG_WIDTH, `CACHE_T, tag bits per line.
- SET_WIDTH, `CACHE_S, index bits.
- OFFSET_WIDTH, `CACHE_B, byte-offset bits; words per line = 2**(OFFSET_WIDTH-2).
- Legality: TAG_WIDTH+SET_WIDTH+OFFSET_WIDTH must equal 32, and OFFSET_WIDTH >= 3.

Ports:
- clk_i, in, 1, clock; all state on posedge.
- rst_i, in, 1, asynchronous active-high reset.
- req_i, in, 1, start a miss service; sampled only in IDLE.
- req_wb_i, in, 1, victim dirty, so write-back is needed; sampled with req_i.
- req_tag_i, in, TAG_WIDTH, tag of missing address.
- victim_tag_i, in, TAG_WIDTH, tag currently held by the line.
- index_i, in, SET_WIDTH, set index of the access.
- busy_o, out, 1, high in every state except IDLE.
- done_o, out, 1, one-cycle pulse in COMMIT.
- line_write_en_o, out, 1, to line write_en_i.
- line_update_en_o, out, 1, to line update_en_i.
- line_set_valid_o, out, 1, to line set_valid_i.
- line_set_dirty_o, out, 1, to line set_dirty_i.
- line_set_tag_o, out, TAG_WIDTH, to line set_tag_i.
- line_offset_o, out, OFFSET_WIDTH-2, to line offset_i.
- line_write_data_o, out, 32, to line write_data_i.
- line_read_data_i, in, 32, from line read_data_o.
- mem_addr_o, out, 32, word-aligned memory address.
- mem_ren_o, out, 1, memory read request.
- mem_wen_o, out, 1, memory write request.
- mem_wdata_o, out, 32, memory write data.
- mem_rdata_i, in, 32, memory read data, valid when mem_ready_i=1.
- mem_ready_i, in, 1, memory completes the current word this cycle.

Behaviour:
- Reset:
  - rst_i=1 asynchronously forces the state to IDLE and clears the word counter and all latched request fields.
  - All outputs read 0 while in reset and in IDLE.
  - Reset mid-transfer abandons the transfer immediately. No done_o is produced and no update_en_o is issued.
- States: IDLE, WB, REFILL, COMMIT. Counter cnt has OFFSET_WIDTH-2 bits.
- IDLE:
  - On posedge with req_i=1, latch req_tag, victim_tag, index and wb; clear cnt.
  - Go to WB if req_wb_i=1, else go to REFILL.
  - req_i=0 stays in IDLE.
- WB:
  - line_set_tag_o=victim_tag, so the line's hit is asserted and read data is ungated.
  - line_offset_o=cnt.
  - mem_wen_o=1, mem_wdata_o=line_read_data_i (combinational pass-through).
  - mem_addr_o={victim_tag,index,cnt,2'b00}.
  - mem_ready_i=1: cnt increments. On the last word (cnt all ones), cnt wraps to 0 and the state goes to REFILL.
  - mem_ready_i=0: hold every output stable.
- REFILL:
  - mem_ren_o=1, mem_addr_o={req_tag,index,cnt,2'b00}.
  - line_set_tag_o=req_tag, line_offset_o=cnt, line_write_data_o=mem_rdata_i.
  - line_write_en_o equals mem_ready_i (same cycle), so the line captures the word on that edge.
  - mem_ready_i=1: cnt increments. On the last word, the state goes to COMMIT.
- COMMIT:
  - line_update_en_o=1, line_set_valid_o=1, line_set_dirty_o=0, line_set_tag_o=req_tag.
  - done_o=1.
  - Next state is IDLE unconditionally.
- mem_ren_o and mem_wen_o are never high together. Once raised, a request and its address stay held until mem_ready_i=1.
- req_i outside IDLE is ignored; it is not queued. req_i sampled in the same cycle as done_o (COMMIT) is ignored.
- The latched fields are immune to input changes after acceptance.
- Latency with mem_ready_i held at 1 and N = 2**(OFFSET_WIDTH-2):
  - Without write-back, done_o is high N+1 cycles after the accept edge.
  - With write-back, done_o is high 2N+1 cycles after the accept edge.
- Each wait cycle with mem_ready_i=0 adds one cycle.

Test Plan (TAG_WIDTH=24, SET_WIDTH=4, OFFSET_WIDTH=4, so N=4):
- Reset: assert rst_i between clock edges during REFILL with cnt=2 -> all outputs read 0 immediately; state returns to IDLE; no done_o ever appears.
- Clean miss: req_i=1, req_wb_i=0, req_tag=24'hABCDEF, index=4'h3, mem_ready_i=1 with rdata 32'h10..13 -> mem_addr_o steps 0xABCDEF30, 0xABCDEF34, 0xABCDEF38, 0xABCDEF3C. The line's write_en pulses on offsets 0..3 with data 0x10..0x13. In the COMMIT cycle, update_en=1, valid=1, dirty=0, tag=0xABCDEF and done_o=1, 5 cycles after the accept edge.
- Dirty miss: victim_tag=24'h000111, index=4'h7, line_read_data_i=offset+0x100 -> first, 4 writes to 0x00011170..0x0001117C with wdata 0x100..0x103; then 4 reads from the req_tag addresses; done_o is high 9 cycles after the accept edge.
- Memory stall: mem_ready_i low for 3 cycles on refill word 1 -> mem_addr_o, mem_ren_o and line_offset_o stay stable and line_write_en_o stays 0 during the stall; done_o is 3 cycles later than the no-stall case.
- Ignored request: pulse req_i with a different tag during REFILL and again in the COMMIT cycle -> no restart; the committed tag is the originally latched one; busy_o drops in the cycle after done_o.
- Back-to-back: assert req_i in the first cycle after the return to IDLE -> it is accepted on that edge and the second miss completes normally.
